// File: rtl/sram_banked_mp.sv
// Multi-port banked SRAM: NUM_PORTS requesters over NUM_BANKS single-port banks,
// fixed-priority arbitration with starvation promotion, byte-enable writes, 1-cycle reads.
module sram_banked_mp #(
  parameter int NUM_PORTS    = 5,
  parameter int NUM_BANKS    = 16,
  parameter int BANK_DEPTH   = 4096,
  parameter int DATA_WIDTH   = 256,
  parameter int ADDR_WIDTH   = 20,
  parameter int XOR_MAP      = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_PORTS-1:0]                    req_valid,
  input  logic [NUM_PORTS-1:0]                    req_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]         req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]         req_wdata,
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0]     req_be,
  output logic [NUM_PORTS-1:0]                    req_ready,
  output logic [NUM_PORTS-1:0]                    rsp_valid,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]         rsp_rdata,
  output logic [31:0]                             conflict_cnt
);

  localparam int BB = $clog2(NUM_BANKS);
  localparam int WB = $clog2(BANK_DEPTH);
  localparam int BE = DATA_WIDTH / 8;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  function automatic logic [BB-1:0] bank_of(input logic [ADDR_WIDTH-1:0] a);
    logic [BB-1:0] h;
    h = (XOR_MAP != 0) ? a[BB+WB-1 -: BB] : '0;
    return a[BB-1:0] ^ h;
  endfunction

  function automatic logic [WB-1:0] word_of(input logic [ADDR_WIDTH-1:0] a);
    return a[BB+WB-1:BB];
  endfunction

  function automatic logic [SW-1:0] starve_next(input logic [SW-1:0] c, input logic waiting);
    if (!waiting) return '0;
    return (c == SW'(STARVE_LIMIT)) ? c : c + SW'(1);
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [BB-1:0]         port_bank [NUM_PORTS];
  logic [NUM_PORTS-1:0]  urgent;
  logic [SW-1:0]         starve_q  [NUM_PORTS];
  logic [SW-1:0]         starve_d  [NUM_PORTS];
  logic [NUM_PORTS-1:0]  rsp_valid_q, rsp_valid_d;
  logic [31:0]           conflict_q, conflict_d;
  logic [BB-1:0]         bank_idx_q [NUM_PORTS];
  logic [BB-1:0]         bank_idx_d [NUM_PORTS];

  logic [NUM_BANKS-1:0]  bank_gnt;
  logic [NUM_BANKS-1:0]  bank_we;
  logic [WB-1:0]         bank_word  [NUM_BANKS];
  logic [DATA_WIDTH-1:0] bank_wdata [NUM_BANKS];
  logic [BE-1:0]         bank_be    [NUM_BANKS];
  logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
  logic [DATA_WIDTH-1:0] mem [NUM_BANKS][BANK_DEPTH];

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_bank[p] = bank_of(req_addr[p*ADDR_WIDTH +: ADDR_WIDTH]);
      urgent[p]    = (starve_q[p] == SW'(STARVE_LIMIT));
    end
  end

  // A port is granted unless a valid port on the same bank outranks it:
  // urgency first, then lower index.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      req_ready[p] = req_valid[p];
      for (int q = 0; q < NUM_PORTS; q++) begin
        if (q != p && req_valid[q] && port_bank[q] == port_bank[p] &&
            ((urgent[q] && !urgent[p]) || (urgent[q] == urgent[p] && q < p)))
          req_ready[p] = 1'b0;
      end
    end
  end

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_gnt[b]   = 1'b0;
      bank_we[b]    = 1'b0;
      bank_word[b]  = '0;
      bank_wdata[b] = '0;
      bank_be[b]    = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (req_ready[p] && port_bank[p] == BB'(b)) begin
          bank_gnt[b]   = 1'b1;
          bank_we[b]    = req_we[p];
          bank_word[b]  = word_of(req_addr[p*ADDR_WIDTH +: ADDR_WIDTH]);
          bank_wdata[b] = req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
          bank_be[b]    = req_be[p*BE +: BE];
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      starve_d[p]   = starve_next(starve_q[p], req_valid[p] & ~req_ready[p]);
      bank_idx_d[p] = port_bank[p];
    end
    rsp_valid_d = req_valid & req_ready & ~req_we;
    conflict_d  = (|(req_valid & ~req_ready)) ? sat_inc32(conflict_q) : conflict_q;
  end

  // Grant edge: bank access, control state update
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_gnt[b]) begin
        if (bank_we[b]) begin
          for (int k = 0; k < BE; k++)
            if (bank_be[b][k]) mem[b][bank_word[b]][8*k +: 8] <= bank_wdata[b][8*k +: 8];
        end else begin
          bank_rdata[b] <= mem[b][bank_word[b]];
        end
      end
    end
    for (int p = 0; p < NUM_PORTS; p++) bank_idx_q[p] <= bank_idx_d[p];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NUM_PORTS; p++) starve_q[p] <= '0;
      rsp_valid_q <= '0;
      conflict_q  <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) starve_q[p] <= starve_d[p];
      rsp_valid_q <= rsp_valid_d;
      conflict_q  <= conflict_d;
    end
  end

  // Response cycle: each port picks its bank's read register by the index captured at grant
  always_comb begin
    rsp_rdata = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      rsp_rdata[p*DATA_WIDTH +: DATA_WIDTH] = bank_rdata[bank_idx_q[p]];
  end

  assign rsp_valid    = rsp_valid_q;
  assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_sram_banked_mp.sv
// Bench for sram_banked_mp: directed scenarios plus randomized traffic checked
// every cycle against a bank-centric behavioural model.
module tb_sram_banked_mp;
  localparam int NP = 5, NB = 16, DEPTH = 4096, DW = 256, AW = 20, XM = 1, SL = 4;
  localparam int BEW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NP-1:0]     req_valid = '0, req_we = '0;
  logic [NP*AW-1:0]  req_addr  = '0;
  logic [NP*DW-1:0]  req_wdata = '0;
  logic [NP*BEW-1:0] req_be    = '0;
  logic [NP-1:0]     req_ready, rsp_valid;
  logic [NP*DW-1:0]  rsp_rdata;
  logic [31:0]       conflict_cnt;

  always #5 clk = ~clk;

  sram_banked_mp #(.NUM_PORTS(NP), .NUM_BANKS(NB), .BANK_DEPTH(DEPTH), .DATA_WIDTH(DW),
                   .ADDR_WIDTH(AW), .XOR_MAP(XM), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .conflict_cnt(conflict_cnt));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Behavioural model state
  logic [DW-1:0]  mm [int];
  logic [BEW-1:0] mk [int];
  int             m_starve [NP], n_starve [NP];
  logic [NP-1:0]  m_rsp_v = '0, n_rsp_v = '0;
  logic [DW-1:0]  m_rsp_d [NP], n_rsp_d [NP];
  logic [BEW-1:0] m_rsp_m [NP], n_rsp_m [NP];
  longint         m_conf = 0, n_conf = 0;
  bit             pend_ok = 0;
  bit             pw_v [NP];
  int             pw_key [NP];
  logic [DW-1:0]  pw_d [NP];
  logic [BEW-1:0] pw_be [NP];
  logic [NP-1:0]  smp_ready = '0;

  function automatic int m_bank(input logic [AW-1:0] a);
    int v, lo, hi;
    v  = int'(a);
    lo = v % NB;
    hi = (v / DEPTH) % NB;
    return (XM != 0) ? (lo ^ hi) : lo;
  endfunction

  function automatic int m_key(input logic [AW-1:0] a);
    return int'(a) % (NB * DEPTH);
  endfunction

  initial begin : model
    logic [NP-1:0] er;
    logic [DW-1:0] bm;
    logic [AW-1:0] a;
    int best, k;
    bit any;
    for (int p = 0; p < NP; p++) begin
      m_starve[p] = 0; n_starve[p] = 0; pw_v[p] = 0;
      m_rsp_m[p] = '0; n_rsp_m[p] = '0; m_rsp_d[p] = '0; n_rsp_d[p] = '0;
    end
    forever begin
      @(negedge clk);
      for (int p = 0; p < NP; p++) begin
        if (pw_v[p]) begin
          if (!mm.exists(pw_key[p])) begin mm[pw_key[p]] = '0; mk[pw_key[p]] = '0; end
          for (int b = 0; b < BEW; b++)
            if (pw_be[p][b]) mm[pw_key[p]][8*b +: 8] = pw_d[p][8*b +: 8];
          mk[pw_key[p]] = mk[pw_key[p]] | pw_be[p];
          pw_v[p] = 0;
        end
      end
      if (rst) begin
        for (int p = 0; p < NP; p++) m_starve[p] = 0;
        m_rsp_v = '0; m_conf = 0; pend_ok = 0;
        chk("model_rst_rsp_valid", rsp_valid, '0);
        chk("model_rst_conflict", conflict_cnt, '0);
        smp_ready = req_ready;
      end else begin
        if (pend_ok) begin
          for (int p = 0; p < NP; p++) begin
            m_starve[p] = n_starve[p]; m_rsp_d[p] = n_rsp_d[p]; m_rsp_m[p] = n_rsp_m[p];
          end
          m_rsp_v = n_rsp_v; m_conf = n_conf;
        end
        er = '0;
        for (int b = 0; b < NB; b++) begin
          best = -1;
          for (int p = 0; p < NP; p++) begin
            if (req_valid[p] && m_bank(req_addr[p*AW +: AW]) == b) begin
              if (best < 0) best = p;
              else if (m_starve[p] == SL && m_starve[best] != SL) best = p;
            end
          end
          if (best >= 0) er[best] = 1'b1;
        end
        chk("req_ready", req_ready, er);
        chk("rsp_valid", rsp_valid, m_rsp_v);
        chk("conflict_cnt", conflict_cnt, m_conf[31:0]);
        for (int p = 0; p < NP; p++) begin
          if (m_rsp_v[p] && m_rsp_m[p] != '0) begin
            for (int b = 0; b < BEW; b++) bm[8*b +: 8] = {8{m_rsp_m[p][b]}};
            chk($sformatf("rsp_rdata%0d", p), rsp_rdata[p*DW +: DW] & bm, m_rsp_d[p] & bm);
          end
        end
        smp_ready = req_ready;
        any = 0;
        for (int p = 0; p < NP; p++) begin
          a = req_addr[p*AW +: AW];
          k = m_key(a);
          if (req_valid[p] && !er[p]) begin
            any = 1;
            n_starve[p] = (m_starve[p] >= SL) ? SL : m_starve[p] + 1;
          end else begin
            n_starve[p] = 0;
          end
          n_rsp_v[p] = req_valid[p] && er[p] && !req_we[p];
          n_rsp_d[p] = mm.exists(k) ? mm[k] : '0;
          n_rsp_m[p] = mk.exists(k) ? mk[k] : '0;
          if (req_valid[p] && er[p] && req_we[p]) begin
            pw_v[p] = 1; pw_key[p] = k;
            pw_d[p] = req_wdata[p*DW +: DW]; pw_be[p] = req_be[p*BEW +: BEW];
          end
        end
        n_conf = any ? ((m_conf == 64'hFFFF_FFFF) ? m_conf : m_conf + 1) : m_conf;
        pend_ok = 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input bit v, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BEW-1:0] be);
    req_valid[p] = v;
    req_we[p]    = we;
    req_addr[p*AW +: AW]   = a;
    req_wdata[p*DW +: DW]  = d;
    req_be[p*BEW +: BEW]   = be;
  endtask

  initial begin : stim
    logic [DW-1:0] a5, rnd;
    logic [15:0]   pool [24];
    logic [31:0]   c0;
    int got;
    a5 = {32{8'hA5}};
    for (int i = 0; i < 24; i++) pool[i] = 16'($urandom);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", req_ready, '0);
    chk("reset_rsp_valid", rsp_valid, '0);
    chk("reset_conflict", conflict_cnt, '0);
    #1 rst = 1'b0;
    step();

    // Write then read
    drive(4, 1, 1, 20'h00123, a5, '1);
    #3 chk("wr_ready4", req_ready[4], 1'b1);
    step();
    req_valid = '0;
    drive(0, 1, 0, 20'h00123, '0, '0);
    #3 chk("rd_ready0", req_ready[0], 1'b1);
    step();
    req_valid = '0;
    chk("rd_rsp_valid", rsp_valid, 5'b00001);
    chk("rd_rdata", rsp_rdata[DW-1:0], a5);
    step();
    chk("rd_rsp_once", rsp_valid, '0);

    // Byte-enable merge
    drive(1, 1, 1, 20'h00040, '1, '1);
    step();
    drive(1, 1, 1, 20'h00040, '0, 32'h0000_0001);
    step();
    drive(1, 1, 0, 20'h00040, '0, '0);
    step();
    req_valid = '0;
    chk("be_rsp_valid", rsp_valid, 5'b00010);
    chk("be_rdata", rsp_rdata[DW +: DW], {{31{8'hFF}}, 8'h00});
    step();

    // Conflict and priority
    c0 = conflict_cnt;
    drive(0, 1, 0, 20'h00123, '0, '0);
    drive(3, 1, 0, 20'h00133, '0, '0);
    #3 chk("conf_ready", req_ready, 5'b00001);
    step();
    chk("conf_cnt_inc", conflict_cnt, c0 + 32'd1);
    req_valid[0] = 1'b0;
    #3 chk("conf_p3_ready", req_ready, 5'b01000);
    step();
    req_valid = '0;
    chk("conf_cnt_hold", conflict_cnt, c0 + 32'd1);
    chk("conf_p3_rsp", rsp_valid, 5'b01000);
    step();

    // Starvation promotion (limit 4)
    got = 0;
    drive(0, 1, 0, 20'h00005, '0, '0);
    drive(2, 1, 0, 20'h00105, '0, '0);
    for (int w = 1; w <= 10 && got == 0; w++) begin
      #3;
      if (req_ready[2]) begin
        got = w;
        chk("starve_p0_denied", req_ready[0], 1'b0);
      end
      step();
    end
    chk("starve_grant_cycle", got, 5);
    #3 chk("starve_cleared", {req_ready[2], req_ready[0]}, 2'b01);
    step();
    req_valid = '0;
    step();

    // Parallelism across banks
    c0 = conflict_cnt;
    for (int p = 0; p < NP; p++) drive(p, 1, 0, AW'(p), '0, '0);
    #3 chk("par_ready", req_ready, 5'b11111);
    step();
    req_valid = '0;
    chk("par_conf", conflict_cnt, c0);
    chk("par_rsp", rsp_valid, 5'b11111);
    step();

    // Reset while a read is in flight
    drive(0, 1, 0, 20'h00123, '0, '0);
    step();
    req_valid = '0;
    chk("rstmid_pre_valid", rsp_valid, 5'b00001);
    #1 rst = 1'b1;
    #1 chk("rstmid_rsp_valid", rsp_valid, '0);
    chk("rstmid_conflict", conflict_cnt, '0);
    step();
    chk("rstmid_held", rsp_valid, '0);
    #1 rst = 1'b0;
    step();
    chk("post_rst_rsp_valid", rsp_valid, '0);
    chk("post_rst_conflict", conflict_cnt, '0);
    drive(2, 1, 0, 20'h00123, '0, '0);
    step();
    req_valid = '0;
    chk("post_rst_valid", rsp_valid, 5'b00100);
    chk("post_rst_rdata", rsp_rdata[2*DW +: DW], a5);
    step();

    // Randomized traffic; a denied request is held unchanged
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (!(req_valid[p] && !smp_ready[p])) begin
          for (int i = 0; i < DW / 32; i++) rnd[32*i +: 32] = $urandom;
          drive(p, $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                {4'($urandom), pool[$urandom_range(0, 23)]}, rnd,
                ($urandom_range(0, 3) == 0) ? '1 : BEW'($urandom));
        end
      end
      step();
    end
    req_valid = '0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
